fetch_unit: RTL and testbench

Parametrised instruction fetch front-end for the dCPU core. It replaces the bare pc register, the +4 adder and the combinational fetch path. It drives a synchronous instruction ROM with a fixed 1-cycle read latency and buffers returned words in a DEPTH-entry queue. It presents instructions to decode through a valid/ready handshake and supports branch redirect (with flush) and halt.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/fetch_unit.sv | 81 ++++++++
 tb/tb_fetch_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared defaults and the queue entry layout for the instruction fetch front-end.
package fetch_pkg;

  localparam int XLEN_DEF = 32;
  localparam logic [XLEN_DEF-1:0] RESET_PC_DEF = '0;

  // One buffered instruction: where it came from and what it is.
  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] ins;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction queue. Flush empties it and wins over a same-cycle push.
// The head data reads as zero while the queue is empty.
module fetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rstd,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             pop_ok;

  assign head_valid = (count != '0);
  assign pop_ok     = pop & head_valid;
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  // Storage write; a flushed push is dropped.
  // NOTE: the storage array has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rstd) begin
    if (rstd) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: pc sequencing, ROM request credit and redirect handling.
// Returned ROM words are tagged with their pc and buffered in fetch_fifo.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter  int              XLEN     = XLEN_DEF,
  parameter  int              IMEM_AW  = 8,
  parameter  int              DEPTH    = 4,
  parameter  logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
  localparam int              CW       = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rstd,
  output logic               imem_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               halt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_ins,
  output logic [XLEN-1:0]    out_pc,
  output logic [CW-1:0]      q_count
);

  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   pend_pc;
  logic              pending;
  logic [CW:0]       credit_used;
  logic              issue;
  logic              push;
  logic [2*XLEN-1:0] head_data;

  // Credit counts queued entries plus the in-flight word; a same-cycle pop is
  // deliberately not credited so the issue path stays short.
  assign credit_used = {1'b0, q_count} + (CW+1)'(pending);
  assign issue       = !rstd && !halt && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign imem_en     = issue;
  assign imem_addr   = fetch_pc[IMEM_AW+1:2];

  // A response arriving in a redirect cycle belongs to the old path and is dropped.
  assign push = pending && !redirect_valid;

  // Fetch pc and in-flight tracking; redirect wins over issue and halt.
  always_ff @(posedge clk or posedge rstd) begin
    if (rstd) begin
      fetch_pc <= RESET_PC;
      pending  <= 1'b0;
      pend_pc  <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~XLEN'(3);
      pending  <= 1'b0;
    end else if (issue) begin
      fetch_pc <= fetch_pc + XLEN'(4);
      pending  <= 1'b1;
      pend_pc  <= fetch_pc;
    end else begin
      pending  <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN)
  ) u_fifo (
    .clk        (clk),
    .rstd       (rstd),
    .push       (push),
    .push_data  ({pend_pc, imem_data}),
    .pop        (out_ready),
    .flush      (redirect_valid),
    .count      (q_count),
    .head_valid (out_valid),
    .head_data  (head_data)
  );

  assign out_pc  = head_data[2*XLEN-1:XLEN];
  assign out_ins = head_data[XLEN-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a cycle model feeds a scoreboard queue of
// expected {pc, ins} entries, compared whenever decode takes the head.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rstd;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ins;
  logic [31:0] out_pc;
  logic [2:0]  q_count;

  int checks;
  int failures;

  fetch_unit #(.XLEN(32), .IMEM_AW(8), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rstd           (rstd),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_ins        (out_ins),
    .out_pc         (out_pc),
    .q_count        (q_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous ROM model: word i holds 0x1000_0000 + i.
  always @(posedge clk) begin
    if (imem_en) imem_data <= 32'h1000_0000 + {24'h0, imem_addr};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model and scoreboard, evaluated mid-cycle.
  fetch_entry_t sb[$];
  fetch_entry_t pend_e;
  logic         pend_v;
  logic [31:0]  exp_pc;
  logic         exp_issue;
  logic         exp_valid;

  always @(negedge clk) begin
    if (rstd) begin
      check("rst_valid", {31'h0, out_valid}, 32'h0);
      check("rst_count", {29'h0, q_count}, 32'h0);
      check("rst_en", {31'h0, imem_en}, 32'h0);
      check("rst_pc", out_pc, 32'h0);
      sb.delete();
      pend_v = 1'b0;
      exp_pc = 32'h0;
    end else begin
      exp_valid = (sb.size() != 0);
      check("mon_valid", {31'h0, out_valid}, {31'h0, exp_valid});
      check("mon_count", {29'h0, q_count}, sb.size());
      if (exp_valid) begin
        check("mon_pc", out_pc, sb[0].pc);
        check("mon_ins", out_ins, sb[0].ins);
      end else begin
        check("mon_empty_pc", out_pc, 32'h0);
        check("mon_empty_ins", out_ins, 32'h0);
      end
      exp_issue = !halt && !redirect_valid && ((sb.size() + int'(pend_v)) < DEPTH);
      check("mon_en", {31'h0, imem_en}, {31'h0, exp_issue});
      if (exp_issue) check("mon_addr", {24'h0, imem_addr}, {24'h0, exp_pc[9:2]});
      if (exp_valid && out_ready) void'(sb.pop_front());
      if (redirect_valid) begin
        sb.delete();
        pend_v = 1'b0;
        exp_pc = redirect_pc & ~32'h3;
      end else begin
        if (pend_v) sb.push_back(pend_e);
        if (exp_issue) begin
          pend_e.pc  = exp_pc;
          pend_e.ins = 32'h1000_0000 + {24'h0, exp_pc[9:2]};
          pend_v     = 1'b1;
          exp_pc     = exp_pc + 32'h4;
        end else begin
          pend_v = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    #1;
    check("redir_no_issue", {31'h0, imem_en}, 32'h0);
    step();
    redirect_valid = 1'b0;
    #1;
  endtask

  initial begin
    bit found;
    checks         = 0;
    failures       = 0;
    rstd           = 1'b0;
    out_ready      = 1'b1;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #1 rstd = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstd = 1'b0;

    // Cycle 0 after release: first issue at RESET_PC.
    #1;
    check("lat_c0_en", {31'h0, imem_en}, 32'h1);
    check("lat_c0_addr", {24'h0, imem_addr}, 32'h0);
    step();
    check("lat_c1_valid", {31'h0, out_valid}, 32'h0);
    check("lat_c1_addr", {24'h0, imem_addr}, 32'h1);
    step();
    check("lat_c2_valid", {31'h0, out_valid}, 32'h1);
    check("lat_c2_pc", out_pc, 32'h0);
    check("lat_c2_ins", out_ins, 32'h1000_0000);
    for (int i = 0; i < 5; i++) begin
      step();
      check("tput_valid", {31'h0, out_valid}, 32'h1);
      check("tput_pc", out_pc, 32'(4 * (i + 1)));
    end

    // Backpressure: queue saturates at DEPTH and issue stops.
    out_ready = 1'b0;
    repeat (10) step();
    check("bp_count", {29'h0, q_count}, DEPTH);
    check("bp_no_issue", {31'h0, imem_en}, 32'h0);
    out_ready = 1'b1;
    repeat (8) step();

    // Redirect with three queued and one in flight.
    out_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (q_count == 3'd3) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check("poll_q3", {31'h0, found}, 32'h1);
    do_redirect(32'h40);
    out_ready = 1'b1;
    check("rd_flush_count", {29'h0, q_count}, 32'h0);
    check("rd_flush_valid", {31'h0, out_valid}, 32'h0);
    check("rd_t1_en", {31'h0, imem_en}, 32'h1);
    check("rd_t1_addr", {24'h0, imem_addr}, 32'h10);
    step();
    check("rd_t2_valid", {31'h0, out_valid}, 32'h0);
    step();
    check("rd_t3_valid", {31'h0, out_valid}, 32'h1);
    check("rd_t3_pc", out_pc, 32'h40);
    check("rd_t3_ins", out_ins, 32'h1000_0010);
    repeat (3) step();

    // Unaligned redirect target is forced to word alignment.
    do_redirect(32'h43);
    check("rd43_addr", {24'h0, imem_addr}, 32'h10);
    step();
    step();
    check("rd43_pc", out_pc, 32'h40);
    repeat (3) step();

    // Halt: no requests, queue drains, then sequential resume.
    halt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("halt_no_issue", {31'h0, imem_en}, 32'h0);
      step();
    end
    check("halt_drained_valid", {31'h0, out_valid}, 32'h0);
    check("halt_drained_count", {29'h0, q_count}, 32'h0);
    halt = 1'b0;
    #1;
    check("halt_resume_en", {31'h0, imem_en}, 32'h1);
    repeat (5) step();

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    repeat (3) step();
    check("mr_nonempty", {31'h0, (q_count != 3'd0)}, 32'h1);
    #2 rstd = 1'b1;
    #1;
    check("mr_valid", {31'h0, out_valid}, 32'h0);
    check("mr_count", {29'h0, q_count}, 32'h0);
    check("mr_en", {31'h0, imem_en}, 32'h0);
    step();
    step();
    rstd = 1'b0;
    out_ready = 1'b1;
    #1;
    check("mr_restart_en", {31'h0, imem_en}, 32'h1);
    check("mr_restart_addr", {24'h0, imem_addr}, 32'h0);
    repeat (4) step();

    // pc wrap at the top of the address space.
    do_redirect(32'hFFFF_FFFC);
    check("wrap_addr_ff", {24'h0, imem_addr}, 32'hFF);
    step();
    check("wrap_addr_00", {24'h0, imem_addr}, 32'h0);
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
